// File: rtl/wddl_pkg.sv
// Shared dual-rail definitions for the WDDL cell library.
// Every WDDL gate and register imports these rail codes.
package wddl_pkg;

    typedef struct packed {
        logic t;
        logic f;
    } rail_t;

    localparam rail_t RAIL_NULL = 2'b00;
    localparam rail_t RAIL_ONE  = 2'b10;
    localparam rail_t RAIL_ZERO = 2'b01;
    localparam rail_t RAIL_BAD  = 2'b11;

endpackage

// File: rtl/wddl_rail_enc.sv
// Single-ended to dual-rail encoder shared by the WDDL gates.
// Precharge yields the null code; evaluate yields {d, ~d}.
module wddl_rail_enc
    import wddl_pkg::*;
(
    input  logic  i_d,
    input  logic  i_prechrg,
    output rail_t o_rail
);

    always_comb begin
        o_rail = RAIL_NULL;
        if (!i_prechrg) begin
            o_rail = i_d ? RAIL_ONE : RAIL_ZERO;
        end
    end

endmodule

// File: rtl/wddl_dflipflop.sv
// WDDL D flip-flop: registered dual-rail outputs that return to 00 every precharge.
// Optional sticky rail-fault flag alarm_o is built when WDDL_DFF_ALARM_EN is defined.
module wddl_dflipflop
    import wddl_pkg::*;
(
    input  logic clk,
    input  logic rst_i,
    input  logic d_i,
    input  logic prechrg_i,
    output logic q_o,
`ifdef WDDL_DFF_ALARM_EN
    output logic qbar_o,
    output logic alarm_o
`else
    output logic qbar_o
`endif
);

    rail_t w_rail;
    logic  r_bit;
    logic  r_q;
    logic  r_qbar;

    wddl_rail_enc u_enc (
        .i_d       (d_i),
        .i_prechrg (prechrg_i),
        .o_rail    (w_rail)
    );

    // The output pair is loaded straight from the encoder so both rails leave
    // the same register stage and cannot glitch against each other.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_bit  <= 1'b0;
            r_q    <= 1'b0;
            r_qbar <= 1'b0;
        end else if (prechrg_i) begin
            r_bit  <= r_bit;
            r_q    <= 1'b0;
            r_qbar <= 1'b0;
        end else begin
            r_bit  <= d_i;
            r_q    <= w_rail.t;
            r_qbar <= w_rail.f;
        end
    end

    assign q_o    = r_q;
    assign qbar_o = r_qbar;

`ifdef WDDL_DFF_ALARM_EN
    logic r_evalSeen;
    logic r_alarm;

    // A null pair right after an evaluate edge means a rail was stuck low.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_evalSeen <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_evalSeen <= ~prechrg_i;
            if ((w_rail == RAIL_BAD) ||
                (r_evalSeen && ({r_q, r_qbar} == RAIL_NULL))) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign alarm_o = r_alarm;
`endif

endmodule

// File: tb/tb_wddl_dflipflop.sv
// Directed self-checking bench for wddl_dflipflop.
// Define WDDL_DFF_ALARM_EN to also exercise the alarm checker.
module tb_wddl_dflipflop;

    logic clk;
    logic rst_i;
    logic d_i;
    logic prechrg_i;
    logic q_o;
    logic qbar_o;
`ifdef WDDL_DFF_ALARM_EN
    logic alarm_o;
`endif

    int checks;
    int errors;

    wddl_dflipflop dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .d_i       (d_i),
        .prechrg_i (prechrg_i),
        .q_o       (q_o),
`ifdef WDDL_DFF_ALARM_EN
        .qbar_o    (qbar_o),
        .alarm_o   (alarm_o)
`else
        .qbar_o    (qbar_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic pre, input logic d);
        @(negedge clk);
        rst_i     = rst;
        prechrg_i = pre;
        d_i       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checks++;
            if ({q_o, qbar_o} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_edge%0d got q/qbar=%b%b expected 00", i, q_o, qbar_o);
            end
`ifdef WDDL_DFF_ALARM_EN
            checks++;
            if (alarm_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_alarm%0d got %b expected 0", i, alarm_o);
            end
`endif
        end
    endtask

    task automatic test_alternating();
        logic [5:0] seq;
        seq = 6'b000101;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, seq[i]);
            checks++;
            if ({q_o, qbar_o} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL alt_pre%0d got q/qbar=%b%b expected 00", i, q_o, qbar_o);
            end
            applyStimulus(1'b0, 1'b0, seq[i]);
            checks++;
            if ({q_o, qbar_o} !== {seq[i], ~seq[i]}) begin
                errors++;
                $display("[TB] FAIL alt_eval%0d got q/qbar=%b%b expected %b%b",
                         i, q_o, qbar_o, seq[i], ~seq[i]);
            end
        end
    endtask

    task automatic test_hold_precharge();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checks++;
        if ({q_o, qbar_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL hold_store got q/qbar=%b%b expected 10", q_o, qbar_o);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checks++;
            if ({q_o, qbar_o} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL hold_pre%0d got q/qbar=%b%b expected 00", i, q_o, qbar_o);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checks++;
        if ({q_o, qbar_o} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL hold_eval got q/qbar=%b%b expected 01", q_o, qbar_o);
        end
    endtask

    task automatic test_reset_mid_eval();
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checks++;
        if ({q_o, qbar_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rst_eval got q/qbar=%b%b expected 00", q_o, qbar_o);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checks++;
        if ({q_o, qbar_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rst_release_pre got q/qbar=%b%b expected 00", q_o, qbar_o);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checks++;
        if ({q_o, qbar_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rst_release_eval got q/qbar=%b%b expected 10", q_o, qbar_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        seq = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, seq[i]);
            checks++;
            if ({q_o, qbar_o} !== {seq[i], ~seq[i]}) begin
                errors++;
                $display("[TB] FAIL b2b_eval%0d got q/qbar=%b%b expected %b%b",
                         i, q_o, qbar_o, seq[i], ~seq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic pre;
        logic d;
        logic [1:0] expPair;
        for (int i = 0; i < 200; i++) begin
            pre = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            expPair = pre ? 2'b00 : {d, ~d};
            applyStimulus(1'b0, pre, d);
            checks++;
            if ((q_o & qbar_o) !== 1'b0 || {q_o, qbar_o} !== expPair) begin
                errors++;
                $display("[TB] FAIL rand%0d pre=%b d=%b got q/qbar=%b%b expected %b",
                         i, pre, d, q_o, qbar_o, expPair);
            end
        end
    endtask

`ifdef WDDL_DFF_ALARM_EN
    task automatic test_alarm();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (alarm_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alarm_idle got %b expected 0", alarm_o);
        end
        @(negedge clk);
        force dut.w_rail = 2'b11;
        prechrg_i = 1'b0;
        @(posedge clk);
        #1;
        release dut.w_rail;
        checks++;
        if (alarm_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alarm_set got %b expected 1", alarm_o);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, i[0], 1'b1);
            checks++;
            if (alarm_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL alarm_sticky%0d got %b expected 1", i, alarm_o);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checks++;
        if (alarm_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alarm_clear got %b expected 0", alarm_o);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_i     = 1'b1;
        d_i       = 1'b1;
        prechrg_i = 1'b0;
        test_reset();
        test_alternating();
        test_hold_precharge();
        test_reset_mid_eval();
        test_back_to_back();
        test_random();
`ifdef WDDL_DFF_ALARM_EN
        test_alarm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
